// File: rtl/brs_link_pkg.sv
// Shared types and constants for the BRS link command responder.
package brs_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOpHold,
    StArg,
    StArgHold
  } state_e;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;

  localparam int unsigned ACK_BIT  = 1;
  localparam int unsigned BUSY_BIT = 2;
  localparam int unsigned ERR_BIT  = 3;
  localparam int unsigned CNT_LSB  = 4;

  localparam logic [7:0] UIO_OE_VAL = 8'hFE;

endpackage

// File: rtl/brs_link_sync2.sv
// Two-flop synchronizer with clock enable; both stages hold while en_i is low.
module brs_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else if (en_i) begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/tt_um_brs_link.sv
// Four-phase handshake command responder: two-byte frames against a 4 x 8-bit register file.
module tt_um_brs_link
  import brs_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       req_s;
  state_e     state_q;
  logic [7:0] opcode_q;
  logic [7:0] regs_q [4];
  logic [7:0] result_q;
  logic       ack_q, busy_q, err_q;
  logic [3:0] cnt_q;

  logic [3:0] op;
  logic [1:0] idx;
  logic       op_valid, op_writes;
  logic [7:0] alu_val;

  logic unused_uio;
  assign unused_uio = ^uio_in[7:1];

  brs_sync2 u_req_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (ena),
    .d_i    (uio_in[0]),
    .q_o    (req_s)
  );

  // Decode the latched opcode; the operand is taken live from ui_in at execute.
  always_comb begin
    op        = opcode_q[7:4];
    idx       = opcode_q[1:0];
    op_valid  = 1'b0;
    op_writes = 1'b0;
    alu_val   = regs_q[idx];
    if (opcode_q[3:2] == 2'b00) begin
      case (op)
        OP_WRITE: begin
          op_valid  = 1'b1;
          op_writes = 1'b1;
          alu_val   = ui_in;
        end
        OP_READ: begin
          op_valid = 1'b1;
        end
        OP_ADD: begin
          op_valid  = 1'b1;
          op_writes = 1'b1;
          alu_val   = regs_q[idx] + ui_in;
        end
        OP_XOR: begin
          op_valid  = 1'b1;
          op_writes = 1'b1;
          alu_val   = regs_q[idx] ^ ui_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      opcode_q <= 8'h00;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
      result_q <= 8'h00;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 4'd0;
    end else if (ena) begin
      case (state_q)
        StIdle: begin
          if (req_s) begin
            opcode_q <= ui_in;
            ack_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StOpHold;
          end
        end
        StOpHold: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= StArg;
          end
        end
        StArg: begin
          if (req_s) begin
            if (op_valid) result_q <= alu_val;
            if (op_writes) regs_q[idx] <= alu_val;
            err_q   <= ~op_valid;
            ack_q   <= 1'b1;
            state_q <= StArgHold;
          end
        end
        StArgHold: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 4'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    uio_out                  = 8'h00;
    uio_out[ACK_BIT]         = ack_q;
    uio_out[BUSY_BIT]        = busy_q;
    uio_out[ERR_BIT]         = err_q;
    uio_out[CNT_LSB +: 4]    = cnt_q;
  end

  assign uo_out = result_q;
  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_brs_link.sv
// Self-checking bench for tt_um_brs_link: directed vector table, random frames vs a model, corners.
module tb_tt_um_brs_link;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_brs_link dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] uo;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [14];

  // Reference model: register file and last visible outputs, from the frame rules.
  int m_regs [4];
  int m_uo, m_err, m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_uo = 0; m_err = 0; m_cnt = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] op, input logic [7:0] arg);
    int kind = int'(op[7:4]);
    int n    = int'(op[1:0]);
    int a    = int'(arg);
    if (op[3:2] != 2'b00 || kind < 1 || kind > 4) begin
      m_err = 1;
    end else begin
      m_err = 0;
      if (kind == 1) m_regs[n] = a;
      else if (kind == 3) m_regs[n] = (m_regs[n] + a) % 256;
      else if (kind == 4) m_regs[n] = m_regs[n] ^ a;
      m_uo = m_regs[n];
    end
    m_cnt = (m_cnt + 1) % 16;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input logic level, input string nm);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uio_out[1] == level) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: ack timeout got %0b expected %0b", nm, uio_out[1], level);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input string nm);
    ui_in     = b;
    uio_in[0] = 1'b1;
    wait_ack(1'b1, nm);
  endtask

  task automatic release_req(input string nm);
    uio_in[0] = 1'b0;
    wait_ack(1'b0, nm);
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [7:0] arg,
                          output logic [7:0] uo, output logic err, output logic [3:0] cnt);
    send_byte(op, "op_ack");
    release_req("op_rel");
    send_byte(arg, "arg_ack");
    uo  = uo_out;
    err = uio_out[3];
    release_req("arg_rel");
    cnt = uio_out[7:4];
  endtask

  logic [7:0] r_uo, r_op, r_arg;
  logic       r_err;
  logic [3:0] r_cnt;

  initial begin
    vecs[0]  = '{8'h12, 8'hA5, 8'hA5, 1'b0, 4'd1};
    vecs[1]  = '{8'h22, 8'h00, 8'hA5, 1'b0, 4'd2};
    vecs[2]  = '{8'h10, 8'hF0, 8'hF0, 1'b0, 4'd3};
    vecs[3]  = '{8'h30, 8'h20, 8'h10, 1'b0, 4'd4};
    vecs[4]  = '{8'h20, 8'h00, 8'h10, 1'b0, 4'd5};
    vecs[5]  = '{8'h13, 8'h0F, 8'h0F, 1'b0, 4'd6};
    vecs[6]  = '{8'h43, 8'hFF, 8'hF0, 1'b0, 4'd7};
    vecs[7]  = '{8'h55, 8'h01, 8'hF0, 1'b1, 4'd8};
    vecs[8]  = '{8'h23, 8'h00, 8'hF0, 1'b0, 4'd9};
    vecs[9]  = '{8'h14, 8'h33, 8'hF0, 1'b1, 4'd10};
    vecs[10] = '{8'h21, 8'h00, 8'h00, 1'b0, 4'd11};
    vecs[11] = '{8'hF0, 8'h12, 8'h00, 1'b1, 4'd12};
    vecs[12] = '{8'h31, 8'hFF, 8'hFF, 1'b0, 4'd13};
    vecs[13] = '{8'h31, 8'h02, 8'h01, 1'b0, 4'd14};

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFE);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_uo", uo_out, 8'h00);
    check("idle_uio", uio_out, 8'h00);

    // Directed table
    foreach (vecs[i]) begin
      do_frame(vecs[i].op, vecs[i].arg, r_uo, r_err, r_cnt);
      model_frame(vecs[i].op, vecs[i].arg);
      check($sformatf("vec%0d_uo", i), r_uo, vecs[i].uo);
      check($sformatf("vec%0d_err", i), r_err, vecs[i].err);
      check($sformatf("vec%0d_cnt", i), r_cnt, vecs[i].cnt);
    end

    // Random frames against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8)
        r_op = {4'($urandom_range(1, 4)), 2'b00, 2'($urandom_range(0, 3))};
      else
        r_op = 8'($urandom);
      r_arg = 8'($urandom);
      do_frame(r_op, r_arg, r_uo, r_err, r_cnt);
      model_frame(r_op, r_arg);
      check($sformatf("rnd%0d_uo", i), r_uo, m_uo);
      check($sformatf("rnd%0d_err", i), r_err, m_err);
      check($sformatf("rnd%0d_cnt", i), r_cnt, m_cnt);
    end

    // Opcode req held for 20 cycles: no second capture
    send_byte(8'h42, "hold_op");
    repeat (20) @(negedge clk);
    check("hold_ack", uio_out[1], 1);
    check("hold_busy", uio_out[2], 1);
    release_req("hold_rel");
    send_byte(8'h5A, "hold_arg");
    model_frame(8'h42, 8'h5A);
    check("hold_uo", uo_out, m_uo);
    release_req("hold_arg_rel");
    check("hold_cnt", uio_out[7:4], m_cnt);

    // Exact ack latency, then operand with ena low for 5 cycles
    @(posedge clk);
    #1 ui_in = 8'h20; uio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_k1", uio_out[1], 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_k2", uio_out[1], 1);
    release_req("lat_rel");
    @(posedge clk);
    #1 ui_in = 8'hC3; uio_in[0] = 1'b1; ena = 1'b0;
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ena_k1", uio_out[1], 0);
    @(posedge clk);
    @(negedge clk);
    check("ena_k2", uio_out[1], 1);
    model_frame(8'h20, 8'hC3);
    check("ena_uo", uo_out, m_uo);
    release_req("ena_rel");
    check("ena_cnt", uio_out[7:4], m_cnt);

    // Reset mid-frame
    send_byte(8'h11, "mid_op");
    rst_n = 1'b0;
    #1;
    check("mid_ack", uio_out[1], 0);
    check("mid_busy", uio_out[2], 0);
    check("mid_uo", uo_out, 8'h00);
    uio_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    // 16 reads: registers cleared, counter wraps back to 0
    for (int i = 0; i < 16; i++) begin
      r_op = {6'b001000, 2'(i % 4)};
      do_frame(r_op, 8'hFF, r_uo, r_err, r_cnt);
      model_frame(r_op, 8'hFF);
      if (i < 4) check($sformatf("clr_reg%0d", i), r_uo, 8'h00);
      if (i == 14) check("cnt15", r_cnt, 4'd15);
      if (i == 15) check("cnt_wrap", r_cnt, 4'd0);
    end
    check("wrap_model", r_cnt, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_brs_link.md
# tt_um_brs_link

Byte-wide, four-phase handshake command responder for the BRS TinyTapeout tile. It is the device-side end of the pin protocol the host (cocotb bench or external controller) drives on ui_in/uio_in. It accepts two-byte command frames (opcode, operand), executes them against a four-entry 8-bit register file, and returns the result on uo_out with an acknowledge and status on uio_out. It is the tile's top-level user module.

## Interface
- No parameters. Register count (4) and width (8) are fixed by the tile pinout.
- clk  input  1  tile clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  tile enable. While low, all state holds.
- ui_in  input  8  command byte from the host; must be stable while req is high.
- uio_in  input  8  bit 0 is req, from the host. Bits 7:1 are ignored.
- uo_out  output  8  result byte.
- uio_out  output  8  bit 0 = 0; bit 1 = ack; bit 2 = busy (mid-frame); bit 3 = err (bad opcode); bits 7:4 = completed-frame counter, low 4 bits.
- uio_oe  output  8  constant 8'hFE. Bit 0 is an input, all other bits drive.

## Operation
- req passes through a 2-flop synchronizer (req_s) before the FSM sees it.
- FSM states:
  - IDLE: on req_s=1, latch ui_in as opcode, set ack=1 and busy=1, go to OP_HOLD.
  - OP_HOLD: on req_s=0, set ack=0, go to ARG.
  - ARG: on req_s=1, latch ui_in as operand, execute, set ack=1, go to ARG_HOLD.
  - ARG_HOLD: on req_s=0, set ack=0 and busy=0, increment the frame counter (wraps 15→0), go to IDLE.
- Opcode decode: opcode[7:4] selects the operation, opcode[1:0] = register index n, opcode[3:2] must be 00.
  - 0x1 WRITE: reg[n] = operand. uo_out = operand.
  - 0x2 READ: operand ignored. uo_out = reg[n].
  - 0x3 ADD: reg[n] = (reg[n] + operand) mod 256. uo_out = new value. The carry is discarded.
  - 0x4 XOR: reg[n] ^= operand. uo_out = new value.
  - Any other opcode, or opcode[3:2] ≠ 00: no register change, uo_out unchanged, err=1.
- err is evaluated at execute. It is set by a bad frame and cleared by the next valid frame's execute.
- A bad opcode still completes the full handshake and still counts as a frame.
- ena=0 freezes the synchronizer, FSM, registers and outputs. Handshake timing stretches accordingly.
- Reset mid-frame discards the partial frame. The host must drop req and restart with an opcode byte.

## Timing
- Reset values: uo_out=8'h00, uio_out=8'h00 (ack=0, busy=0, err=0, count=0), all reg[n]=8'h00, FSM=IDLE. uio_oe=8'hFE always.
- Ack latency: req rising at the pin is sampled on edge k. ack is high after edge k+2 (2 sync flops, FSM registers on the 2nd-flop output).
- Ack release: ack falls after edge k+2 following req falling.
- uo_out, err and count are updated on the same edge that raises the operand ack, or drops the final ack (count only). They are valid whenever ack is high.
- Host rules: hold ui_in stable from req rise until ack rises; do not raise req again until ack is low.
- req glitches shorter than one clock may be missed; this is not an error case.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package brs_link_pkg holds:
  - the state enum (IDLE, OP_HOLD, ARG, ARG_HOLD);
  - opcode constants OP_WRITE=4'h1, OP_READ=4'h2, OP_ADD=4'h3, OP_XOR=4'h4;
  - the uio_out bit-index constants (ACK_BIT=1, BUSY_BIT=2, ERR_BIT=3, CNT_LSB=4);
  - UIO_OE_VAL=8'hFE.
- One sub-module, brs_sync2: a 2-flop synchronizer with asynchronous active-low reset to 0, instantiated once for req.
- Register file, decode and FSM live in the top module.

## Test plan
- Reset: hold rst_n=0 → uo_out=00, uio_out=00, uio_oe=FE. Release, idle 10 cycles → outputs unchanged.
- WRITE then READ: frame (12, A5), then frame (22, 00) → uo_out=A5 after each operand ack. err=0, count=2.
- ADD wrap: write reg0=F0, then frame (30, 20) → uo_out=10, reg0=10 (carry dropped).
- XOR and err clearing:
  - write reg3=0F, then frame (43, FF) → uo_out=F0;
  - then frame (55, 01) → err=1, uo_out stays F0, count increments;
  - then frame (23, 00) → err=0, uo_out=F0.
- Handshake timing: raise req, count edges → ack high after the 2nd edge. Hold req high 20 cycles → ack stays high, no second capture. ena=0 for 5 cycles mid-frame → ack delayed 5 cycles.
- Reset mid-frame and counter wrap:
  - after the opcode ack, assert rst_n=0 → ack=0 and busy=0 immediately; registers return to 00;
  - then 16 complete frames → count returns to 0.
